strip_mine_seq: RTL and testbench
=================================

Name: strip_mine_seq

Overview:
- Consumer side of the vector-length setup function: takes a whole-vector request (encoded SEW, encoded LMUL, total AVL) and emits the sequence of per-strip vl grants the execution datapath consumes.
- Per strip: vl = min(remaining, VLMAX) and the element offset of the strip.
- Sits between the vector decode stage and the lane issue logic.
- Replaces repeated combinational vl recomputation with a registered strip sequencer that uses a valid/ready handshake.

Parameters:
- VLEN, 128, vector register length in bits. Must be a power of two, 128..1024.
- AVL_W, 9, width of AVL, vl and offset fields.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- sew_code  in  3  000=8, 001=16, 010=32, 011=64, 100=128; 101..111 invalid.
- lmul_code  in  3  000=1, 001=2, 010=4, 011=8, 100=16; 101..111 invalid.
- AVL  in  AVL_W  total element count, unsigned.
- busy  out  1  high while a request is in progress (ISSUE or DONE state).
- err  out  1  one-cycle pulse when a start carries an invalid code.
- strip_valid  out  1  strip grant valid.
- strip_ready  in  1  downstream accepts the strip.
- strip_vl  out  AVL_W  element count of the current strip.
- strip_off  out  AVL_W  element offset of the first element of the current strip.
- strip_last  out  1  current strip is the final one.
- done  out  1  one-cycle pulse after the final strip handshake, or after a zero-length request.

Behaviour:
- **Reset** (rst_n=0 at a clock edge): state=IDLE; busy, err, strip_valid, strip_last and done are 0; strip_vl, strip_off and remaining are 0. Reset mid-operation abandons the request with no done pulse.
- **VLMAX**: VLMAX = (VLEN >> (sew_code+3)) << lmul_code. Computed once at start and registered, at width AVL_W+1 (VLEN=128 gives max 256). Held constant for the whole request.
- **Strip width**: each strip has vl = min(remaining, VLMAX), compared at full width with no truncation.
- **States**: IDLE, ISSUE, DONE.
- **IDLE**:
  - start with any invalid code: err=1 for the next cycle only, stay IDLE, no strips issued.
  - start with valid codes and AVL=0: go to DONE with no strips.
  - start with valid codes and AVL>0: remaining=AVL, off=0, go to ISSUE.
  - strip_valid rises the cycle after start (latency 1).
- **ISSUE**:
  - strip_valid=1. strip_vl, strip_off and strip_last are registered and held stable while strip_valid && !strip_ready.
  - On handshake (valid && ready): off += vl, remaining -= vl. If strip_last was set, go to DONE and drop strip_valid the next cycle. Otherwise present the next strip the very next cycle, so back-to-back handshakes are possible at 1 strip/cycle.
  - strip_last = (remaining <= VLMAX).
- **DONE**: done=1 for exactly one cycle, busy still 1, then IDLE. A new start is accepted from the cycle after DONE.
- **start while busy**: ignored. Sampled inputs are not re-read mid-request.
- **Invariants**:
  - Sum of issued strip_vl equals AVL.
  - Every strip except the last has vl=VLMAX.
  - No strip has vl=0.
  - strip_off + strip_vl never exceeds AVL, so there is no wrap.
- **err and done**: mutually exclusive per request.

Test Plan:
- sew_code=0, lmul_code=0 (VLMAX=16), AVL=40, ready held 1 → strips (vl,off,last) = (16,0,0), (16,16,0), (8,32,1) on consecutive cycles; done pulses 1 cycle later; busy deasserts the cycle after done.
- sew_code=0, lmul_code=4 (VLMAX=256), AVL=300 → strips (256,0,0), (44,256,1). Also AVL=256 exactly → one strip (256,0,1).
- Same 40-element request with ready toggled 0,0,1 per strip → outputs held stable while ready=0; strip sequence identical to the first test.
- sew_code=5 and start, then lmul_code=7 and start → err pulses 1 cycle each; strip_valid, busy and done stay 0.
- AVL=0 with valid codes → no strip_valid; done pulses at cycle start+1. Separately, sew_code=4, lmul_code=0 (VLMAX=1), AVL=3 → three vl=1 strips at offsets 0, 1, 2, the last with strip_last=1.
- rst_n=0 during the second strip of the 40-element request → next cycle all outputs are 0 and state is IDLE with no done pulse; a fresh start then gives correct strips from off=0. A start asserted while busy is ignored.

Source files
------------

// File: rtl/strip_mine_seq.sv
`default_nettype none
// ============================================================================
//  Module   : strip_mine_seq
//  Purpose  : Strip-mining sequencer for vector-length setup. Accepts a
//             whole-vector request (encoded SEW, encoded LMUL, total AVL)
//             and emits a registered sequence of per-strip vl grants, each
//             vl = min(remaining, VLMAX), together with the element offset
//             of the strip, over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    VLEN        vector register length in bits (power of two, 128..1024)
//    AVL_W       width of the AVL, vl and offset fields
//  Ports
//    clk         clock, rising edge
//    rst_n       synchronous active-low reset
//    start       request pulse, sampled only while idle
//    sew_code    element width code   (000=8 .. 100=128, others invalid)
//    lmul_code   register group code  (000=1 .. 100=16,  others invalid)
//    AVL         total element count of the request
//    busy        request in progress
//    err         one-cycle pulse after a start with an invalid code
//    strip_valid strip grant valid
//    strip_ready downstream accepts the current strip
//    strip_vl    element count of the current strip
//    strip_off   offset of the first element of the current strip
//    strip_last  current strip is the final one
//    done        one-cycle pulse after the last strip (or a zero-length start)
// ============================================================================
module strip_mine_seq #(
  parameter int VLEN  = 128,
  parameter int AVL_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       sew_code,
  input  logic [2:0]       lmul_code,
  input  logic [AVL_W-1:0] AVL,
  output logic             busy,
  output logic             err,
  output logic             strip_valid,
  input  logic             strip_ready,
  output logic [AVL_W-1:0] strip_vl,
  output logic [AVL_W-1:0] strip_off,
  output logic             strip_last,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Any VLMAX at or above 2^AVL_W behaves identically, since no request can
  // hold more than 2^AVL_W-1 elements; clamp there so the register stays at
  // AVL_W+1 bits even for the largest VLEN/LMUL combinations.
  localparam int unsigned VL_CAP = 32'd1 << AVL_W;

  state_t             state;
  logic [AVL_W:0]     vlmax;      // held for the whole request
  logic [AVL_W-1:0]   remaining;  // elements not yet handed off, incl. current strip

  logic               codes_ok;
  logic [31:0]        vlmax_wide;
  logic [AVL_W:0]     vlmax_calc;
  logic [AVL_W-1:0]   rem_after;

  // Smaller of the remaining count and VLMAX, compared at full width.
  function automatic logic [AVL_W-1:0] clamp_vl(input logic [AVL_W-1:0] rem,
                                                input logic [AVL_W:0]   cap);
    if ({1'b0, rem} <= cap) begin
      clamp_vl = rem;
    end else begin
      clamp_vl = cap[AVL_W-1:0];
    end
  endfunction

  assign codes_ok   = (sew_code <= 3'd4) && (lmul_code <= 3'd4);
  assign vlmax_wide = (32'(VLEN) >> ({29'd0, sew_code} + 32'd3)) << lmul_code;

  always_comb begin
    vlmax_calc = vlmax_wide[AVL_W:0];
    if (vlmax_wide > VL_CAP) begin
      vlmax_calc = (AVL_W+1)'(VL_CAP);
    end
  end

  assign rem_after = remaining - strip_vl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      vlmax       <= '0;
      remaining   <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      strip_valid <= 1'b0;
      strip_vl    <= '0;
      strip_off   <= '0;
      strip_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      // err and done are single-cycle pulses
      err  <= 1'b0;
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (!codes_ok) begin
              err <= 1'b1;
            end else if (AVL == '0) begin
              // Zero-length request: no strips, straight to completion.
              busy  <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              vlmax       <= vlmax_calc;
              remaining   <= AVL;
              strip_off   <= '0;
              strip_vl    <= clamp_vl(AVL, vlmax_calc);
              strip_last  <= ({1'b0, AVL} <= vlmax_calc);
              strip_valid <= 1'b1;
              busy        <= 1'b1;
              state       <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          // Strip fields only move on a handshake, so they hold under stall.
          if (strip_valid && strip_ready) begin
            remaining <= rem_after;
            strip_off <= strip_off + strip_vl;
            if (strip_last) begin
              strip_valid <= 1'b0;
              strip_last  <= 1'b0;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              strip_vl   <= clamp_vl(rem_after, vlmax);
              strip_last <= ({1'b0, rem_after} <= vlmax);
            end
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          strip_valid <= 1'b0;
          strip_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_strip_mine_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_strip_mine_seq
//  Purpose  : Directed self-checking bench for strip_mine_seq (VLEN=128,
//             AVL_W=9) with hand-computed expected strip sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_strip_mine_seq;

  localparam int VLEN  = 128;
  localparam int AVL_W = 9;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       sew_code;
  logic [2:0]       lmul_code;
  logic [AVL_W-1:0] avl;
  logic             busy;
  logic             err;
  logic             strip_valid;
  logic             strip_ready;
  logic [AVL_W-1:0] strip_vl;
  logic [AVL_W-1:0] strip_off;
  logic             strip_last;
  logic             done;

  int total;
  int bad;

  strip_mine_seq #(
    .VLEN  (VLEN),
    .AVL_W (AVL_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sew_code    (sew_code),
    .lmul_code   (lmul_code),
    .AVL         (avl),
    .busy        (busy),
    .err         (err),
    .strip_valid (strip_valid),
    .strip_ready (strip_ready),
    .strip_vl    (strip_vl),
    .strip_off   (strip_off),
    .strip_last  (strip_last),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; everything is driven and sampled 1 time unit after
  // the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check that the given strip is being presented (and no done/err).
  task automatic see_strip(input string tag, input int vl, input int off, input int last);
    check({tag, ".valid"}, 32'(strip_valid), 32'd1);
    check({tag, ".vl"},    32'(strip_vl),    32'(vl));
    check({tag, ".off"},   32'(strip_off),   32'(off));
    check({tag, ".last"},  32'(strip_last),  32'(last));
    check({tag, ".busy"},  32'(busy),        32'd1);
    check({tag, ".done"},  32'(done),        32'd0);
  endtask

  // Pulse start for one cycle with the given request.
  task automatic issue(input logic [2:0] s, input logic [2:0] l, input int a);
    sew_code  = s;
    lmul_code = l;
    avl       = AVL_W'(a);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // After the final handshake: done pulse with busy, then idle.
  task automatic see_done(input string tag);
    check({tag, ".done"},   32'(done),        32'd1);
    check({tag, ".busy"},   32'(busy),        32'd1);
    check({tag, ".valid"},  32'(strip_valid), 32'd0);
    tick();
    check({tag, ".done0"},  32'(done),        32'd0);
    check({tag, ".idle"},   32'(busy),        32'd0);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    sew_code    = 3'd0;
    lmul_code   = 3'd0;
    avl         = '0;
    strip_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst.busy",  32'(busy),        32'd0);
    check("rst.err",   32'(err),         32'd0);
    check("rst.valid", 32'(strip_valid), 32'd0);
    check("rst.vl",    32'(strip_vl),    32'd0);
    check("rst.off",   32'(strip_off),   32'd0);
    check("rst.last",  32'(strip_last),  32'd0);
    check("rst.done",  32'(done),        32'd0);
    rst_n = 1'b1;
    tick();

    // VLMAX=16, AVL=40, ready held high
    strip_ready = 1'b1;
    issue(3'd0, 3'd0, 40);
    see_strip("a40.s0", 16, 0, 0);
    tick();
    see_strip("a40.s1", 16, 16, 0);
    tick();
    see_strip("a40.s2", 8, 32, 1);
    tick();
    see_done("a40");

    // VLMAX=256, AVL=300
    issue(3'd0, 3'd4, 300);
    see_strip("a300.s0", 256, 0, 0);
    tick();
    see_strip("a300.s1", 44, 256, 1);
    tick();
    see_done("a300");

    // VLMAX=256, AVL=256 exactly: one strip
    issue(3'd0, 3'd4, 256);
    see_strip("a256.s0", 256, 0, 1);
    tick();
    see_done("a256");

    // Same 40-element request with ready 0,0,1 per strip
    strip_ready = 1'b0;
    issue(3'd0, 3'd0, 40);
    for (int s = 0; s < 3; s++) begin
      int vl_e;
      vl_e = (s == 2) ? 8 : 16;
      strip_ready = 1'b0;
      see_strip($sformatf("stall.s%0d.a", s), vl_e, 16 * s, (s == 2) ? 1 : 0);
      tick();
      see_strip($sformatf("stall.s%0d.b", s), vl_e, 16 * s, (s == 2) ? 1 : 0);
      tick();
      see_strip($sformatf("stall.s%0d.c", s), vl_e, 16 * s, (s == 2) ? 1 : 0);
      strip_ready = 1'b1;
      tick();
    end
    see_done("stall");

    // Invalid codes
    issue(3'd5, 3'd0, 10);
    check("inv_sew.err",   32'(err),         32'd1);
    check("inv_sew.valid", 32'(strip_valid), 32'd0);
    check("inv_sew.busy",  32'(busy),        32'd0);
    check("inv_sew.done",  32'(done),        32'd0);
    tick();
    check("inv_sew.err0",  32'(err),         32'd0);
    check("inv_sew.valid0",32'(strip_valid), 32'd0);
    issue(3'd0, 3'd7, 10);
    check("inv_lmul.err",   32'(err),         32'd1);
    check("inv_lmul.valid", 32'(strip_valid), 32'd0);
    check("inv_lmul.busy",  32'(busy),        32'd0);
    check("inv_lmul.done",  32'(done),        32'd0);
    tick();
    check("inv_lmul.err0",  32'(err),         32'd0);
    check("inv_lmul.done0", 32'(done),        32'd0);

    // AVL=0: done at start+1, no strips
    issue(3'd0, 3'd0, 0);
    check("zero.err", 32'(err), 32'd0);
    see_done("zero");

    // VLMAX=1 (sew=128, lmul=1), AVL=3
    issue(3'd4, 3'd0, 3);
    see_strip("v1.s0", 1, 0, 0);
    tick();
    see_strip("v1.s1", 1, 1, 0);
    tick();
    see_strip("v1.s2", 1, 2, 1);
    tick();
    see_done("v1");

    // Reset during the second strip
    issue(3'd0, 3'd0, 40);
    see_strip("rs.s0", 16, 0, 0);
    tick();
    see_strip("rs.s1", 16, 16, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rs.valid", 32'(strip_valid), 32'd0);
    check("rs.busy",  32'(busy),        32'd0);
    check("rs.vl",    32'(strip_vl),    32'd0);
    check("rs.off",   32'(strip_off),   32'd0);
    check("rs.last",  32'(strip_last),  32'd0);
    check("rs.done",  32'(done),        32'd0);
    tick();
    check("rs.done2", 32'(done),        32'd0);

    // Fresh request; a different start held high while busy is ignored
    issue(3'd0, 3'd0, 40);
    see_strip("rb.s0", 16, 0, 0);
    sew_code  = 3'd4;
    lmul_code = 3'd0;
    avl       = AVL_W'(5);
    start     = 1'b1;
    tick();
    see_strip("rb.s1", 16, 16, 0);
    tick();
    see_strip("rb.s2", 8, 32, 1);
    tick();
    start = 1'b0;
    see_done("rb");
    check("rb.err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
